pwm_multi_gen: RTL

PWM_MULTI_GEN -- requirements
Module: pwm_multi_gen

---
 rtl/pwm_multi_gen.sv | 137 +++++++++++++
 1 files changed

// File: rtl/pwm_multi_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : pwm_multi_gen
// Purpose  : Multi-channel PWM generator sharing one prescaled up-counter;
//            per-channel compare/mode registers are double-buffered.
// Revision : 1.0
// ============================================================================
module pwm_multi_gen #(
    parameter  int NCH  = 4,
    parameter  int CW   = 16,
    parameter  int PSW  = 8,
    localparam int SELW = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic [CW-1:0]   period,
    input  logic [PSW-1:0]  prescale,
    input  logic            ch_wr,
    input  logic [SELW-1:0] ch_sel,
    input  logic [CW-1:0]   ch_cmp1,
    input  logic [CW-1:0]   ch_cmp2,
    input  logic [1:0]      ch_mode,
    input  logic [NCH-1:0]  ch_en,
    output logic [CW-1:0]   count_val,
    output logic            period_tick,
    output logic [NCH-1:0]  pwm_out
);

    localparam logic [CW-1:0]  c_cnt_one    = CW'(1);
    localparam logic [PSW-1:0] c_psc_one    = PSW'(1);
    localparam logic [1:0]     c_mode_left  = 2'b00;
    localparam logic [1:0]     c_mode_right = 2'b01;
    localparam logic [1:0]     c_mode_range = 2'b10;

    logic [PSW-1:0] r_psc;
    logic [CW-1:0]  r_count;
    logic           r_tick;
    logic [NCH-1:0] r_pwm;
    logic [NCH-1:0] w_pwm_next;
    logic           w_adv;
    logic           w_top;
    logic           w_wrap;
    logic           w_load;

    assign w_adv  = (r_psc == prescale);
    // ">=" rather than "==" so a period lowered below the count still wraps
    assign w_top  = (r_count >= period);
    assign w_wrap = en & w_adv & w_top;
    assign w_load = ~en | w_wrap;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_psc   <= '0;
            r_count <= '0;
            r_tick  <= 1'b0;
        end else if (!en) begin
            r_psc   <= '0;
            r_tick  <= 1'b0;
        end else if (w_adv) begin
            r_psc <= '0;
            if (w_top) begin
                r_count <= '0;
                r_tick  <= 1'b1;
            end else begin
                r_count <= r_count + c_cnt_one;
                r_tick  <= 1'b0;
            end
        end else begin
            r_psc  <= r_psc + c_psc_one;
            r_tick <= 1'b0;
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic [CW-1:0] r_shd_cmp1;
        logic [CW-1:0] r_shd_cmp2;
        logic [1:0]    r_shd_mode;
        logic [CW-1:0] r_act_cmp1;
        logic [CW-1:0] r_act_cmp2;
        logic [1:0]    r_act_mode;
        logic          w_sel;
        logic          w_level;

        assign w_sel = ch_wr & (ch_sel == SELW'(i));

        always_comb begin
            w_level = 1'b0;
            case (r_act_mode)
                c_mode_left:  w_level = (r_count < r_act_cmp1);
                c_mode_right: w_level = (r_count >= r_act_cmp1);
                c_mode_range: w_level = (r_count >= r_act_cmp1) && (r_count < r_act_cmp2);
                default:      w_level = !(r_count < r_act_cmp1);
            endcase
        end

        assign w_pwm_next[i] = en & ch_en[i] & w_level;

        // Active copies the pre-write shadow when a write lands on a wrap
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_shd_cmp1 <= '0;
                r_shd_cmp2 <= '0;
                r_shd_mode <= 2'b00;
                r_act_cmp1 <= '0;
                r_act_cmp2 <= '0;
                r_act_mode <= 2'b00;
            end else begin
                if (w_sel) begin
                    r_shd_cmp1 <= ch_cmp1;
                    r_shd_cmp2 <= ch_cmp2;
                    r_shd_mode <= ch_mode;
                end
                if (w_load) begin
                    r_act_cmp1 <= r_shd_cmp1;
                    r_act_cmp2 <= r_shd_cmp2;
                    r_act_mode <= r_shd_mode;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pwm <= '0;
        end else begin
            r_pwm <= w_pwm_next;
        end
    end

    assign count_val   = r_count;
    assign period_tick = r_tick;
    assign pwm_out     = r_pwm;

endmodule
`default_nettype wire
